// File: rtl/aes128_type_pkg.sv
// rtl/aes128_type_pkg.sv - shared AES-128 types and register-interface constants
//
// Purpose: operation mode type, register word addresses, CTRL/STATUS bit
// positions and the register-interface FSM state type.
// Ports: none (package).
package aes128_type_pkg;

  typedef enum logic [1:0] {
    MODE_ENC = 2'd0,
    MODE_DEC = 2'd1
  } mode_t;

  // Word addresses of the register map
  localparam int unsigned RI_ADDR_KEY0    = 0;
  localparam int unsigned RI_ADDR_DATA0   = 4;
  localparam int unsigned RI_ADDR_CTRL    = 8;
  localparam int unsigned RI_ADDR_STATUS  = 9;
  localparam int unsigned RI_ADDR_RESULT0 = 10;
  localparam int unsigned RI_ADDR_RESULT3 = 13;

  // CTRL bit positions
  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_OP_LSB     = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 3;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_DONE_BIT = 1;
  localparam int unsigned STATUS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    RI_IDLE  = 2'd0,
    RI_ISSUE = 2'd1,
    RI_RUN   = 2'd2
  } reg_if_state_t;

endpackage

// File: rtl/aes128_reg_if.sv
// rtl/aes128_reg_if.sv - CPU register block and start/done handshake for the AES-128 engine
//
// Purpose: collects key, data and opcode from 32-bit writes, issues a
// one-cycle start to the engine, captures the result with a sticky done
// flag and optional level interrupt, and serves reads with 1-cycle latency.
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   addr_i, wdata_i         word address and write data
//   wr_en_i, rd_en_i        write / read strobes
//   rdata_o, rvalid_o       registered read data and its valid pulse
//   irq_o                   registered level interrupt (done & irq_en)
//   start_o, op_o           start pulse and operation to the engine
//   key_o, data_o           128-bit key and input block (word n at [32n+31:32n])
//   ready_i, valid_i        engine idle / result valid (level)
//   result_i                engine result
module aes128_reg_if
  import aes128_type_pkg::*;
#(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  output logic [31:0]       rdata_o,
  output logic              rvalid_o,
  output logic              irq_o,
  output logic              start_o,
  output logic [1:0]        op_o,
  output logic [127:0]      key_o,
  output logic [127:0]      data_o,
  input  logic              ready_i,
  input  logic              valid_i,
  input  logic [127:0]      result_i
);

  reg_if_state_t    state_q;
  logic [3:0][31:0] key_q, data_q, result_q;
  mode_t            op_q;
  logic             irq_en_q, done_q, done_d, err_q, err_d;
  logic             valid_q, irq_q, rvalid_q;
  logic [31:0]      rdata_q, rd_mux;

  logic       busy, complete, start_req, cfg_wr;
  logic       hit_key, hit_data, hit_ctrl, hit_status, hit_result;
  logic [1:0] res_idx;

  // Address decode
  assign hit_key    = (addr_i <  ADDR_W'(RI_ADDR_DATA0));
  assign hit_data   = (addr_i >= ADDR_W'(RI_ADDR_DATA0)) && (addr_i < ADDR_W'(RI_ADDR_CTRL));
  assign hit_ctrl   = (addr_i == ADDR_W'(RI_ADDR_CTRL));
  assign hit_status = (addr_i == ADDR_W'(RI_ADDR_STATUS));
  assign hit_result = (addr_i >= ADDR_W'(RI_ADDR_RESULT0)) && (addr_i <= ADDR_W'(RI_ADDR_RESULT3));
  // RESULT0 sits at 10, so the word index is the low two address bits minus 2 (mod 4)
  assign res_idx    = addr_i[1:0] - 2'd2;

  assign busy      = (state_q != RI_IDLE);
  assign cfg_wr    = wr_en_i && (hit_key || hit_data || hit_ctrl);
  assign start_req = !busy && wr_en_i && hit_ctrl && wdata_i[CTRL_START_BIT];
  assign complete  = (state_q == RI_RUN) && valid_i && !valid_q;

  // Sticky flags: a completion outranks a same-cycle write-1-to-clear
  always_comb begin
    done_d = done_q;
    if (wr_en_i && hit_status && wdata_i[STATUS_DONE_BIT]) done_d = 1'b0;
    if (start_req) done_d = 1'b0;
    if (complete)  done_d = 1'b1;

    err_d = err_q;
    if (wr_en_i && hit_status && wdata_i[STATUS_ERR_BIT]) err_d = 1'b0;
    if (busy && cfg_wr) err_d = 1'b1;
  end

  always_comb begin
    rd_mux = '0;
    if (hit_key) begin
      rd_mux = key_q[addr_i[1:0]];
    end else if (hit_data) begin
      rd_mux = data_q[addr_i[1:0]];
    end else if (hit_ctrl) begin
      rd_mux[CTRL_IRQ_EN_BIT]    = irq_en_q;
      rd_mux[CTRL_OP_LSB +: 2]   = op_q;
    end else if (hit_status) begin
      rd_mux[STATUS_BUSY_BIT] = busy;
      rd_mux[STATUS_DONE_BIT] = done_q;
      rd_mux[STATUS_ERR_BIT]  = err_q;
    end else if (hit_result) begin
      rd_mux = result_q[res_idx];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= RI_IDLE;
      key_q    <= '0;
      data_q   <= '0;
      result_q <= '0;
      op_q     <= MODE_ENC;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      valid_q  <= valid_i;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= done_q & irq_en_q;
      rvalid_q <= rd_en_i;
      if (rd_en_i) rdata_q <= rd_mux;

      // Configuration is frozen while the engine owns it
      if (wr_en_i && !busy) begin
        if (hit_key)  key_q[addr_i[1:0]]  <= wdata_i;
        if (hit_data) data_q[addr_i[1:0]] <= wdata_i;
        if (hit_ctrl) begin
          op_q     <= mode_t'(wdata_i[CTRL_OP_LSB +: 2]);
          irq_en_q <= wdata_i[CTRL_IRQ_EN_BIT];
        end
      end

      case (state_q)
        RI_IDLE:  if (start_req) state_q <= RI_ISSUE;
        RI_ISSUE: if (ready_i)   state_q <= RI_RUN;
        RI_RUN: begin
          if (complete) begin
            result_q <= result_i;
            state_q  <= RI_IDLE;
          end
        end
        default:  state_q <= RI_IDLE;
      endcase
    end
  end

  // Combinational so the pulse lands in the exact cycle the engine is ready
  assign start_o  = (state_q == RI_ISSUE) && ready_i;
  assign op_o     = op_q;
  assign key_o    = key_q;
  assign data_o   = data_q;
  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign irq_o    = irq_q;

endmodule

// File: doc/aes128_reg_if.md
# aes128_reg_if

Bus-facing register block for the AES-128 peripheral, upstream of the `aes128_fsm` engine. It collects the key, data and opcode from 32-bit CPU writes, and issues a single-cycle start to the engine through a ready handshake. When the engine finishes it captures the 128-bit result, sets a sticky done flag with an optional interrupt, and returns register contents on a one-cycle read pipeline.

## Interface
Parameters:
- `ADDR_W`, default 4: word-address width. The map uses 14 of 16 words.

Ports:
- `clk_i`  in  1  — single clock; all state is on the rising edge.
- `rst_i`  in  1  — reset, asynchronous and active-high.
- `addr_i`  in  ADDR_W  — word address for reads and writes.
- `wdata_i`  in  32  — write data.
- `wr_en_i`  in  1  — write strobe; a full 32-bit write completes in one cycle.
- `rd_en_i`  in  1  — read strobe.
- `rdata_o`  out  32  — read data, registered.
- `rvalid_o`  out  1  — high for one cycle when `rdata_o` holds read data.
- `irq_o`  out  1  — level interrupt, registered.
- `start_o`  out  1  — start pulse to the engine.
- `op_o`  out  2  — operation: 0 = encrypt, 1 = decrypt.
- `key_o`  out  128  — key; word n drives bits [32n+31:32n].
- `data_o`  out  128  — input block; same word packing as `key_o`.
- `ready_i`  in  1  — engine idle.
- `valid_i`  in  1  — engine result valid (level; falls after the next start).
- `result_i`  in  128  — engine result.

## Operation
Address map:
- 0–3: KEY0–3, read/write.
- 4–7: DATA0–3, read/write.
- 8: CTRL.
  - Write: bit0 start (self-clearing), bits 2:1 op, bit3 irq_en.
  - Read: {irq_en, op, 0}.
- 9: STATUS.
  - Bit0 busy, bit1 done, bit2 err.
  - Bits 1 and 2 are write-1-to-clear.
- 10–13: RESULT0–3, read-only.
- 14–15: read 0, writes ignored.

State machine `IDLE → ISSUE → RUN → IDLE`:
- **IDLE**
  - A CTRL write with bit0 = 1 latches op and irq_en, clears done, and moves to ISSUE.
  - A CTRL write with bit0 = 0 only updates op and irq_en.
- **ISSUE**
  - Waits for `ready_i`.
  - In the cycle `ready_i` = 1, `start_o` = 1 and the next state is RUN.
  - `start_o` is combinational from state & `ready_i`, so it is exactly one cycle wide.
- **RUN**
  - Completion is the rising edge of `valid_i`, detected as `valid_i & ~valid_q`.
  - On completion: RESULT ← `result_i`, done ← 1, next state IDLE.
- busy = (state ≠ IDLE).

Rules while busy:
- Writes to KEY, DATA or CTRL are ignored and set err.
- STATUS and read accesses behave normally.

Other rules:
- `key_o`, `data_o` and `op_o` are driven straight from the registers and stay stable from ISSUE until return to IDLE.
- RESULT holds the last completed operation and is not cleared by a new start.
- `irq_o` is registered: `irq_o` ← done & irq_en.
- Writes or reads to addresses 14–15 are harmless: no err, reads return 0.

## Timing
- Reset values: every register, done, err and the valid edge flop are 0; state is IDLE.
- Reset output values: `rdata_o`, `rvalid_o`, `irq_o`, `start_o`, `op_o`, `key_o`, `data_o` are all 0.
- A reset mid-operation returns to IDLE and drops `start_o` immediately. The engine is reset by the same top-level reset.
- Read latency is 1 cycle: `rd_en_i` at T gives `rdata_o` and `rvalid_o` = 1 at T+1.
- A read and a write to the same address in the same cycle returns the pre-write value.
- Start latency: CTRL write at T puts the FSM in ISSUE at T+1, and `start_o` is asserted at T+1 if `ready_i` = 1.
- Completion: a `valid_i` rise at T updates RESULT, done and IDLE at T+1, and `irq_o` at T+2.
- A STATUS write-1-to-clear of done in the same cycle as completion: set wins, done = 1.
- Back-to-back starts: the second start is accepted at the first cycle where state = IDLE.

## Structure
- Additions to `aes128_type_pkg`:
  - localparams for register addresses.
  - CTRL/STATUS bit indices.
  - enum `reg_if_state_t {RI_IDLE, RI_ISSUE, RI_RUN}`.
- The block reuses `mode_t` from `aes128_type_pkg` for op.
- No sub-module is needed; this is a single module.
- The peripheral top connects this block to `aes128_fsm`.

## Test plan
- **FIPS-197 encrypt**
  - Stimulus: KEY3..0 = 00010203, 04050607, 08090a0b, 0c0d0e0f; DATA3..0 = 00112233, 44556677, 8899aabb, ccddeeff; CTRL = 0x9.
  - Required: `start_o` is one pulse, busy = 1 until done, then RESULT3..0 = 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; STATUS = 0x2; `irq_o` = 1.
- **Decrypt**
  - Stimulus: same key; DATA = the ciphertext above; CTRL = 0x3 (op = 1).
  - Required: RESULT = plaintext 00112233…ccddeeff; `irq_o` stays 0 because irq_en = 0.
- **Write while busy**
  - Stimulus: write KEY0 = ffffffff and CTRL = 0x1 during RUN.
  - Required: KEY0 and `key_o` are unchanged; STATUS bit2 = 1; only one `start_o` pulse. Writing STATUS = 0x4 clears err.
- **Ready stall**
  - Stimulus: hold `ready_i` = 0 for 5 cycles after a start write.
  - Required: FSM stays in ISSUE, `start_o` = 0 throughout, then `start_o` pulses exactly once on the first cycle `ready_i` = 1.
- **Reset and W1C race**
  - Stimulus: assert `rst_i` mid-RUN; separately, write STATUS = 0x2 in the same cycle as a `valid_i` rise.
  - Required: after the reset, all outputs are 0 and STATUS = 0. In the race, done = 1 after the cycle.
- **Read pipeline**
  - Stimulus: a read of addr 9 concurrent with a write of 0x2 to addr 9, while done = 1.
  - Required: `rdata_o` = 0x2 at T+1; a subsequent read returns 0x0.
